// File: rtl/button_repeat.sv
// Purpose: per-button 2-flop synchronizer, debounce filter and typematic auto-repeat pulse generator.
// Latency: level/press pulse appear DEBOUNCE_CYCLES+2 edges after btn_in is first sampled; all outputs registered.
// Backpressure: none; btn_down is a fire-and-forget one-cycle pulse, consumer must accept every cycle.
module button_repeat #(
  parameter int PortWidth       = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PortWidth-1:0] btn_in,
  output logic [PortWidth-1:0] btn_level,
  output logic [PortWidth-1:0] btn_down
);

  // One counter width serves both the debounce and repeat counters; the extra
  // bit keeps the saturation value strictly above every terminal count.
  localparam int MaxDr    = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MaxCount = (MaxDr > REPEAT_PERIOD) ? MaxDr : REPEAT_PERIOD;
  localparam int CW       = $clog2(MaxCount) + 1;

  // Terminal values are "count before the edge that would reach the limit".
  localparam logic [CW-1:0] DbLast     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DelayLast  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PeriodLast = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] CntMax     = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  logic [PortWidth-1:0] s1, s2;
  logic [CW-1:0]        db_cnt [PortWidth];
  logic [PortWidth-1:0] flip, rise, fall;

  state_t               state      [PortWidth];
  state_t               state_next [PortWidth];
  logic [CW-1:0]        rep_cnt      [PortWidth];
  logic [CW-1:0]        rep_cnt_next [PortWidth];
  logic [PortWidth-1:0] down_next;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CntMax) ? v : v + CW'(1);
  endfunction

  // Two-flop synchronizer; only s2 feeds the debounce logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  // Level flips on the edge where the mismatch count would reach DEBOUNCE_CYCLES.
  always_comb begin
    flip = '0;
    for (int b = 0; b < PortWidth; b++) begin
      flip[b] = (s2[b] != btn_level[b]) && (db_cnt[b] == DbLast);
    end
  end

  assign rise = flip & ~btn_level;
  assign fall = flip & btn_level;

  // Debounce counter: any cycle of agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_level <= '0;
      for (int b = 0; b < PortWidth; b++) begin
        db_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < PortWidth; b++) begin
        if (s2[b] == btn_level[b]) begin
          db_cnt[b] <= '0;
        end else if (flip[b]) begin
          db_cnt[b]    <= '0;
          btn_level[b] <= ~btn_level[b];
        end else begin
          db_cnt[b] <= db_cnt[b] + CW'(1);
        end
      end
    end
  end

  // Repeat FSM state, counter and registered pulse output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_down <= '0;
      for (int b = 0; b < PortWidth; b++) begin
        state[b]   <= IDLE;
        rep_cnt[b] <= '0;
      end
    end else begin
      btn_down <= down_next;
      for (int b = 0; b < PortWidth; b++) begin
        state[b]   <= state_next[b];
        rep_cnt[b] <= rep_cnt_next[b];
      end
    end
  end

  // Next-state logic; a falling level overrides any expiring count so release never pulses.
  always_comb begin
    down_next = '0;
    for (int b = 0; b < PortWidth; b++) begin
      state_next[b]   = state[b];
      rep_cnt_next[b] = rep_cnt[b];
      if (fall[b]) begin
        state_next[b]   = IDLE;
        rep_cnt_next[b] = '0;
      end else begin
        case (state[b])
          IDLE: begin
            if (rise[b]) begin
              state_next[b]   = HOLD;
              rep_cnt_next[b] = '0;
              down_next[b]    = 1'b1;
            end
          end
          HOLD: begin
            if ((REPEAT_DELAY != 0) && (rep_cnt[b] == DelayLast)) begin
              state_next[b]   = REPEAT;
              rep_cnt_next[b] = '0;
              down_next[b]    = 1'b1;
            end else begin
              rep_cnt_next[b] = sat_inc(rep_cnt[b]);
            end
          end
          REPEAT: begin
            if (rep_cnt[b] == PeriodLast) begin
              rep_cnt_next[b] = '0;
              down_next[b]    = 1'b1;
            end else begin
              rep_cnt_next[b] = sat_inc(rep_cnt[b]);
            end
          end
          default: begin
            state_next[b]   = IDLE;
            rep_cnt_next[b] = '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_repeat.sv
// Purpose: self-checking bench for button_repeat with directed scenarios and randomized traffic.
// Latency: checks sample outputs on the falling clock edge, half a cycle after each update.
// Backpressure: not applicable; inputs are driven freely on falling edges.
`timescale 1ns/1ps
module tb_button_repeat;
  localparam int PW = 4;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [PW-1:0] btn_in = '0;
  logic [PW-1:0] btn_level;
  logic [PW-1:0] btn_down;

  int n_chk = 0;
  int n_pass = 0;

  button_repeat #(
    .PortWidth(PW), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .btn_level(btn_level), .btn_down(btn_down)
  );

  always #5 clk = ~clk;

  // Reference model: keeps every raw sample since reset. A level flips when the
  // DB synchronized samples preceding an edge all disagree with it; pulses come
  // at the press edge and at press+RD+k*RP while the level stays high.
  logic [PW-1:0] samp [$];
  logic [PW-1:0] m_level = '0;
  logic [PW-1:0] m_down = '0;
  int            press_at [PW];

  always @(posedge clk or posedge reset) begin
    int n;
    bit flip;
    int d;
    if (reset) begin
      samp.delete();
      m_level = '0;
      m_down  = '0;
    end else begin
      samp.push_back(btn_in);
      n = samp.size() - 1;
      for (int b = 0; b < PW; b++) begin
        flip = (n >= DB + 1);
        if (flip) begin
          for (int k = n - 1 - DB; k <= n - 2; k++) begin
            if (samp[k][b] == m_level[b]) flip = 1'b0;
          end
        end
        m_down[b] = 1'b0;
        if (flip) begin
          m_level[b] = ~m_level[b];
          if (m_level[b]) begin
            m_down[b]   = 1'b1;
            press_at[b] = n;
          end
        end else if (m_level[b] && RD != 0) begin
          d = n - press_at[b];
          if (d == RD || (d > RD && ((d - RD) % RP) == 0)) m_down[b] = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    btn_in = '0;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    // Power-on: reset rises with no clock edge yet.
    #1 reset = 1'b1;
    #1;
    n_chk++;
    if (btn_level !== '0 || btn_down !== '0) $display("FAIL reset_initial: level=%b down=%b want 0000/0000", btn_level, btn_down);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    // Bring button 0 up, then reset mid-cycle and expect immediate clearing.
    btn_in = 4'b0001;
    repeat (8) tick();
    n_chk++;
    if (btn_level !== 4'b0001) $display("FAIL reset_pre_level: level=%b want 0001", btn_level);
    else n_pass++;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_chk++;
    if (btn_level !== '0 || btn_down !== '0) $display("FAIL reset_async: level=%b down=%b want 0000/0000", btn_level, btn_down);
    else n_pass++;
    btn_in = '0;
    @(negedge clk);
    reset = 1'b0;
    settle();
  endtask

  task automatic test_clean_press();
    int pulses;
    int pulse_at;
    int fall_at;
    pulses = 0; pulse_at = 0; fall_at = 0;
    btn_in[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_chk++;
      if (btn_level !== m_level || btn_down !== m_down) $display("FAIL press_model i=%0d: level=%b down=%b want %b/%b", i, btn_level, btn_down, m_level, m_down);
      else n_pass++;
      if (btn_down[0]) begin pulses++; pulse_at = i; end
    end
    n_chk++;
    if (pulses !== 1 || pulse_at !== 6) $display("FAIL press_pulse: count=%0d at=%0d want 1 at 6", pulses, pulse_at);
    else n_pass++;
    btn_in[0] = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_chk++;
      if (btn_level !== m_level || btn_down !== m_down) $display("FAIL release_model i=%0d: level=%b down=%b want %b/%b", i, btn_level, btn_down, m_level, m_down);
      else n_pass++;
      if (btn_down[0]) pulses++;
      if (!btn_level[0] && fall_at == 0) fall_at = i;
    end
    n_chk++;
    if (pulses !== 0 || fall_at !== 6) $display("FAIL release_fall: pulses=%0d fall_at=%0d want 0 and 6", pulses, fall_at);
    else n_pass++;
    settle();
  endtask

  task automatic test_bounce();
    int pulses;
    int pulse_at;
    int level_seen;
    pulses = 0; pulse_at = 0; level_seen = 0;
    for (int seg = 0; seg < 4; seg++) begin
      btn_in[1] = (seg % 2 == 0);
      repeat (3) begin
        tick();
        if (btn_level[1] || btn_down[1]) level_seen++;
      end
    end
    n_chk++;
    if (level_seen !== 0) $display("FAIL bounce_quiet: active cycles=%0d want 0", level_seen);
    else n_pass++;
    btn_in[1] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_chk++;
      if (btn_level !== m_level || btn_down !== m_down) $display("FAIL bounce_model i=%0d: level=%b down=%b want %b/%b", i, btn_level, btn_down, m_level, m_down);
      else n_pass++;
      if (btn_down[1]) begin pulses++; pulse_at = i; end
    end
    n_chk++;
    if (pulses !== 1 || pulse_at !== 6) $display("FAIL bounce_pulse: count=%0d at=%0d want 1 at 6", pulses, pulse_at);
    else n_pass++;
    settle();
  endtask

  task automatic test_auto_repeat();
    int p_tick;
    bit exp;
    p_tick = 0;
    btn_in[2] = 1'b1;
    for (int i = 1; i <= 10 && p_tick == 0; i++) begin
      tick();
      if (btn_down[2]) p_tick = i;
    end
    n_chk++;
    if (p_tick !== 6) $display("FAIL repeat_press: pulse tick=%0d want 6", p_tick);
    else n_pass++;
    for (int t = 1; t <= 80; t++) begin
      tick();
      exp = (t == 20 || t == 28 || t == 36 || t == 44 || t == 52 || t == 60);
      n_chk++;
      if (btn_down[2] !== exp) $display("FAIL repeat_pulse P+%0d: down=%b want %b", t, btn_down[2], exp);
      else n_pass++;
      if (t == 60) btn_in[2] = 1'b0;
    end
    settle();
  endtask

  task automatic test_simultaneous();
    logic [PW-1:0] got;
    got = '0;
    btn_in = 4'b0011;
    for (int i = 1; i <= 10 && got == '0; i++) begin
      tick();
      got = btn_down;
    end
    n_chk++;
    if (got !== 4'b0011) $display("FAIL simultaneous: down=%b want 0011", got);
    else n_pass++;
    settle();
  endtask

  task automatic test_reset_held();
    int p_tick;
    int bad;
    bit exp;
    p_tick = 0; bad = 0;
    btn_in[0] = 1'b1;
    for (int i = 1; i <= 10 && p_tick == 0; i++) begin
      tick();
      if (btn_down[0]) p_tick = i;
    end
    n_chk++;
    if (p_tick !== 6) $display("FAIL held_press: pulse tick=%0d want 6", p_tick);
    else n_pass++;
    repeat (25) tick();
    reset = 1'b1;
    #1;
    n_chk++;
    if (btn_level !== '0 || btn_down !== '0) $display("FAIL held_reset_async: level=%b down=%b want 0000/0000", btn_level, btn_down);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (btn_down !== '0) bad++;
    end
    n_chk++;
    if (bad !== 0) $display("FAIL held_reset_quiet: pulse cycles=%0d want 0", bad);
    else n_pass++;
    reset = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      exp = (t == 6 || t == 26);
      n_chk++;
      if (btn_down[0] !== exp) $display("FAIL held_after_reset t=%0d: down=%b want %b", t, btn_down[0], exp);
      else n_pass++;
    end
    settle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < PW; b++) begin
        if ($urandom_range(0, 15) == 0) btn_in[b] = ~btn_in[b];
      end
      if (c == 700) begin
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
      end
      tick();
      n_chk++;
      if (btn_level !== m_level || btn_down !== m_down) $display("FAIL random_model c=%0d: level=%b down=%b want %b/%b", c, btn_level, btn_down, m_level, m_down);
      else n_pass++;
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_simultaneous();
    test_reset_held();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
